// File: rtl/priority_iter_encoder.sv
// Iterative priority encoder: latches pad flags/counts on a delayed strobe and emits up to
// MXCLUSTERS clusters, lowest pad first. Optional OVERFLOW_CNT_EN adds a saturating overflow counter.
`timescale 1ns/1ps
module priority_iter_encoder #(
  parameter int MXPADS     = 768,
  parameter int MXADRB     = 10,
  parameter int MXCNTB     = 3,
  parameter int MXCLUSTERS = 8,
  parameter int MXIDXB     = 3
) (
  input  logic                       clock,
  input  logic                       global_reset,
  input  logic [3:0]                 latch_delay,
  input  logic                       latch_in,
  input  logic [MXPADS-1:0]          vpfs_in,
  input  logic [MXPADS*MXCNTB-1:0]   cnts_in,
  output logic                       cluster_valid,
  output logic [MXADRB-1:0]          adr,
  output logic [MXCNTB-1:0]          cnt,
  output logic [MXIDXB-1:0]          idx,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
`ifdef OVERFLOW_CNT_EN
  ,
  output logic [15:0]                overflow_cnt
`endif
);

  typedef enum logic {S_IDLE, S_SEARCH} state_t;

  state_t                     r_state, w_state_nxt;
  logic [14:0]                r_srl;
  logic                       r_latch_en;
  logic                       w_tap;
  logic [MXPADS-1:0]          r_mask, w_mask_nxt, w_rest;
  logic [MXPADS*MXCNTB-1:0]   r_cnts;
  logic [MXIDXB-1:0]          r_count, w_count_nxt;
  logic                       w_hit;
  logic [MXADRB-1:0]          w_adr;
  logic [MXCNTB-1:0]          w_cnt;
  logic                       r_valid, w_valid_nxt;
  logic [MXADRB-1:0]          r_adr, w_adr_nxt;
  logic [MXCNTB-1:0]          r_cnt, w_cnt_nxt;
  logic [MXIDXB-1:0]          r_idx, w_idx_nxt;
  logic                       r_done, w_done_nxt;
  logic                       r_ovf, w_ovf_nxt;

  // Delay 0 bypasses the shift register so the output register alone gives one clock.
  always_comb w_tap = (latch_delay == 4'd0) ? latch_in : r_srl[latch_delay - 4'd1];

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      r_srl      <= '0;
      r_latch_en <= 1'b0;
    end else begin
      r_srl      <= {r_srl[13:0], latch_in};
      r_latch_en <= w_tap;
    end
  end

  always_comb begin
    w_adr = '0;
    w_cnt = '0;
    for (int unsigned i = MXPADS; i > 0; i--) begin
      if (r_mask[i-1]) begin
        w_adr = MXADRB'(i - 1);
        w_cnt = r_cnts[(i-1)*MXCNTB +: MXCNTB];
      end
    end
  end

  // x & (x-1) drops exactly the lowest set bit, i.e. the pad being emitted.
  always_comb begin
    w_hit  = |r_mask;
    w_rest = r_mask & (r_mask - MXPADS'(1));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_count_nxt = r_count;
    w_valid_nxt = 1'b0;
    w_adr_nxt   = '0;
    w_cnt_nxt   = '0;
    w_idx_nxt   = '0;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    if (r_latch_en) begin
      w_state_nxt = S_SEARCH;
      w_mask_nxt  = vpfs_in;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_SEARCH: begin
          if (w_hit) begin
            w_valid_nxt = 1'b1;
            w_adr_nxt   = w_adr;
            w_cnt_nxt   = w_cnt;
            w_idx_nxt   = r_count;
            w_mask_nxt  = w_rest;
            w_count_nxt = r_count + MXIDXB'(1);
            if (r_count == MXIDXB'(MXCLUSTERS - 1)) begin
              w_done_nxt  = 1'b1;
              w_ovf_nxt   = |w_rest;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_cnts  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_adr   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      r_adr   <= w_adr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
      if (r_latch_en) r_cnts <= cnts_in;
    end
  end

`ifdef OVERFLOW_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset)                        r_ovf_cnt <= '0;
    else if (w_ovf_nxt && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  assign overflow_cnt = r_ovf_cnt;
`endif

  assign cluster_valid = r_valid;
  assign adr           = r_adr;
  assign cnt           = r_cnt;
  assign idx           = r_idx;
  assign done          = r_done;
  assign overflow      = r_ovf;
  assign busy          = (r_state == S_SEARCH);

endmodule

// File: tb/tb_priority_iter_encoder.sv
// Scoreboard bench for priority_iter_encoder: directed events push expected outputs tagged
// with the cycle they must appear in; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_priority_iter_encoder;

  localparam int MXPADS = 768;
  localparam int MXCNTB = 3;

  logic                     clock = 1'b0;
  logic                     global_reset;
  logic [3:0]               latch_delay;
  logic                     latch_in;
  logic [MXPADS-1:0]        vpfs_in;
  logic [MXPADS*MXCNTB-1:0] cnts_in;
  logic                     cluster_valid;
  logic [9:0]               adr;
  logic [2:0]               cnt;
  logic [2:0]               idx;
  logic                     busy;
  logic                     done;
  logic                     overflow;
`ifdef OVERFLOW_CNT_EN
  logic [15:0]              overflow_cnt;
`endif

  priority_iter_encoder #(
    .MXPADS(768), .MXADRB(10), .MXCNTB(3), .MXCLUSTERS(8), .MXIDXB(3)
  ) dut (
    .clock(clock), .global_reset(global_reset), .latch_delay(latch_delay),
    .latch_in(latch_in), .vpfs_in(vpfs_in), .cnts_in(cnts_in),
    .cluster_valid(cluster_valid), .adr(adr), .cnt(cnt), .idx(idx),
    .busy(busy), .done(done), .overflow(overflow)
`ifdef OVERFLOW_CNT_EN
    , .overflow_cnt(overflow_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic       v;
    logic [9:0] a;
    logic [2:0] c;
    logic [2:0] i;
    logic       d;
    logic       o;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int c, input logic v, input int a, input int n,
                      input int i, input logic d, input logic o);
    exp_t x;
    x.cyc = c; x.v = v; x.a = 10'(a); x.c = 3'(n); x.i = 3'(i); x.d = d; x.o = o;
    q.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic strobe();
    latch_in = 1'b1;
    @(negedge clock);
    latch_in = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!global_reset) begin
      if (cluster_valid || done) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: cyc=%0d v=%0b adr=%0d cnt=%0d idx=%0d done=%0b ovf=%0b, required none",
                   cyc, cluster_valid, adr, cnt, idx, done, overflow);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || cluster_valid !== e.v || adr !== e.a || cnt !== e.c ||
              idx !== e.i || done !== e.d || overflow !== e.o) begin
            n_err++;
            $display("FAIL cluster: got cyc=%0d v=%0b adr=%0d cnt=%0d idx=%0d done=%0b ovf=%0b, required cyc=%0d v=%0b adr=%0d cnt=%0d idx=%0d done=%0b ovf=%0b",
                     cyc, cluster_valid, adr, cnt, idx, done, overflow,
                     e.cyc, e.v, e.a, e.c, e.i, e.d, e.o);
          end
        end
      end else if (adr != 0 || cnt != 0 || idx != 0 || overflow) begin
        n_cmp++;
        n_err++;
        $display("FAIL idle_outputs: got adr=%0d cnt=%0d idx=%0d ovf=%0b, required 0", adr, cnt, idx, overflow);
      end
    end
  end

  initial begin
    int k;
    global_reset = 1'b1;
    latch_delay  = 4'd0;
    latch_in     = 1'b0;
    vpfs_in      = '0;
    cnts_in      = '0;
    @(negedge clock);
    check("reset_outputs", int'({cluster_valid, adr, cnt, idx, busy, done, overflow}), 0);
    @(negedge clock);
    global_reset = 1'b0;
    repeat (3) @(negedge clock);

    // Delay 3: pads 5, 700, 767.
    k = cyc;
    latch_delay = 4'd3;
    vpfs_in = '0; cnts_in = '0;
    vpfs_in[5] = 1'b1;   cnts_in[5*3 +: 3]   = 3'd2;
    vpfs_in[700] = 1'b1; cnts_in[700*3 +: 3] = 3'd7;
    vpfs_in[767] = 1'b1; cnts_in[767*3 +: 3] = 3'd1;
    push(k+6, 1, 5,   2, 0, 0, 0);
    push(k+7, 1, 700, 7, 1, 0, 0);
    push(k+8, 1, 767, 1, 2, 0, 0);
    push(k+9, 0, 0,   0, 0, 1, 0);
    strobe();
    wait_cyc(k+4); check("busy_before_capture_d3", int'(busy), 0);
    wait_cyc(k+5); check("busy_after_capture_d3", int'(busy), 1);
    wait_cyc(k+9); check("busy_after_done", int'(busy), 0);
    wait_cyc(k+25);

    // All pads set, cnt = i%8: eight clusters, overflow with the eighth.
    k = cyc;
    latch_delay = 4'd0;
    vpfs_in = '1;
    for (int i = 0; i < MXPADS; i++) cnts_in[i*3 +: 3] = 3'(i % 8);
    for (int j = 0; j < 8; j++) push(k+3+j, 1, j, j, j, (j == 7), (j == 7));
    strobe();
    wait_cyc(k+25);
`ifdef OVERFLOW_CNT_EN
    check("overflow_cnt_one", int'(overflow_cnt), 1);
`endif

    // Zero hits: done alone two cycles after capture.
    k = cyc;
    vpfs_in = '0; cnts_in = '0;
    push(k+3, 0, 0, 0, 0, 1, 0);
    strobe();
    wait_cyc(k+20);

    // Abort: second strobe after two clusters of a 6-hit event.
    k = cyc;
    vpfs_in = '0; cnts_in = '0;
    for (int j = 1; j <= 6; j++) begin
      vpfs_in[j*10] = 1'b1;
      cnts_in[j*30 +: 3] = 3'd3;
    end
    push(k+3, 1, 10, 3, 0, 0, 0);
    push(k+4, 1, 20, 3, 1, 0, 0);
    push(k+6, 1, 100, 4, 0, 0, 0);
    push(k+7, 1, 200, 5, 1, 0, 0);
    push(k+8, 0, 0,   0, 0, 1, 0);
    strobe();
    wait_cyc(k+3);
    vpfs_in = '0; cnts_in = '0;
    vpfs_in[100] = 1'b1; cnts_in[100*3 +: 3] = 3'd4;
    vpfs_in[200] = 1'b1; cnts_in[200*3 +: 3] = 3'd5;
    strobe();
    wait_cyc(k+5); check("busy_on_recapture", int'(busy), 1);
    wait_cyc(k+25);

    // Delay 15: pad 0 captured 16 clocks after the strobe.
    k = cyc;
    latch_delay = 4'd15;
    vpfs_in = '0; cnts_in = '0;
    vpfs_in[0] = 1'b1; cnts_in[2:0] = 3'd6;
    push(k+18, 1, 0, 6, 0, 0, 0);
    push(k+19, 0, 0, 0, 0, 1, 0);
    strobe();
    wait_cyc(k+16); check("busy_before_capture_d15", int'(busy), 0);
    wait_cyc(k+17); check("busy_after_capture_d15", int'(busy), 1);
    wait_cyc(k+35);

    // Reset in the middle of a search.
    k = cyc;
    latch_delay = 4'd0;
    vpfs_in = '1;
    for (int i = 0; i < MXPADS; i++) cnts_in[i*3 +: 3] = 3'(i % 8);
    push(k+3, 1, 0, 0, 0, 0, 0);
    push(k+4, 1, 1, 1, 1, 0, 0);
    strobe();
    wait_cyc(k+4);
    #2 global_reset = 1'b1;
    #1 check("reset_midsearch_outputs", int'({cluster_valid, adr, cnt, idx, done, overflow}), 0);
    check("reset_midsearch_busy", int'(busy), 0);
`ifdef OVERFLOW_CNT_EN
    check("overflow_cnt_cleared", int'(overflow_cnt), 0);
`endif
    @(negedge clock);
    global_reset = 1'b0;
    repeat (20) @(negedge clock);
    check("busy_idle_after_reset", int'(busy), 0);

    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
